// File: rtl/booth_mac_acc_if.sv
// -----------------------------------------------------------------------------
// booth_mac_acc_if
// Beat/result handshake bundle for the Booth multiply-accumulate stage.
//   in_valid / in_ready / in_prod / in_last    : product beats from Booth_mul
//   out_valid / out_ready / out_acc / out_cnt / out_ovf : block result
// Modports:
//   master : the environment (drives beats, accepts results)
//   slave  : the accumulate stage
// -----------------------------------------------------------------------------
interface booth_mac_acc_if #(
  parameter int LENGTH    = 32,
  parameter int ACC_WIDTH = 72,
  parameter int MAX_BEATS = 16
) ();
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  logic                  in_valid;
  logic                  in_ready;
  logic [2*LENGTH-1:0]   in_prod;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_acc;
  logic [CNT_W-1:0]      out_cnt;
  logic                  out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf
  );
endinterface

// File: rtl/booth_mac_acc.sv
// -----------------------------------------------------------------------------
// booth_mac_acc
// Sequential accumulate stage behind the combinational Booth_mul array. Each
// accepted product is first captured in a pipe register (breaking the long
// multiplier-to-adder path), then added into a wide accumulator. A block ends
// on in_last or when MAX_BEATS beats have been accepted; the block total is
// then offered on the out_* handshake and held until taken.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : booth_mac_acc_if.slave (beat input and result output handshakes)
//
// Build option:
//   BOOTH_ACC_SAT_EN : when defined the accumulator clamps on overflow
//                      (all-ones unsigned, max-pos/min-neg signed) instead of
//                      wrapping; out_ovf reports the event either way.
// -----------------------------------------------------------------------------
module booth_mac_acc #(
  parameter int LENGTH        = 32,
  parameter int ACC_WIDTH     = 72,
  parameter int MAX_BEATS     = 16,
  parameter bit UNSIGNED_MODE = 1'b1
) (
  input logic            clk,
  input logic            rst,
  booth_mac_acc_if.slave bus
);
  localparam int PW    = 2 * LENGTH;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam int MSB   = ACC_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

  state_t               state;
  logic [PW-1:0]        p_r;
  logic                 p_v;
  logic                 p_last;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 accept;
  logic [CNT_W:0]       cnt_accept;
  logic                 beat_last;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH:0]   sum_full;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0]     cnt_nxt;

  assign bus.in_ready = (state == IDLE) || (state == ACC);
  assign accept       = bus.in_valid && bus.in_ready;

  // Beats accepted so far in this block, counting the one arriving now and
  // the one still waiting in the pipe register (cnt lags accept by a cycle).
  assign cnt_accept = {1'b0, cnt} + (CNT_W+1)'(p_v) + (CNT_W+1)'(1);
  assign beat_last  = bus.in_last || (cnt_accept == (CNT_W+1)'(MAX_BEATS));
  assign cnt_nxt    = cnt + CNT_W'(1);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    if (UNSIGNED_MODE) p_ext = ACC_WIDTH'(p_r);
    else               p_ext = ACC_WIDTH'($signed(p_r));

    sum_full = {1'b0, acc} + {1'b0, p_ext};

    if (UNSIGNED_MODE) add_ovf = sum_full[ACC_WIDTH];
    else               add_ovf = (acc[MSB] == p_ext[MSB]) && (sum_full[MSB] != acc[MSB]);

    acc_nxt = sum_full[ACC_WIDTH-1:0];
`ifdef BOOTH_ACC_SAT_EN
    if (add_ovf) begin
      if (UNSIGNED_MODE)  acc_nxt = '1;
      // Signed overflow only happens when both operands share a sign, so the
      // accumulator's sign picks the rail.
      else if (acc[MSB])  acc_nxt = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                acc_nxt = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      p_r           <= '0;
      p_v           <= 1'b0;
      p_last        <= 1'b0;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_acc   <= '0;
      bus.out_cnt   <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      p_v <= accept;
      if (accept) begin
        p_r    <= bus.in_prod;
        p_last <= beat_last;
      end

      // A pipe bubble (p_v=0) leaves the running sum untouched.
      if (p_v) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        ovf <= ovf | add_ovf;
      end

      case (state)
        IDLE, ACC: begin
          if (accept) state <= beat_last ? DRAIN : ACC;
        end
        DRAIN: begin
          // The closing beat sits in the pipe now; publish the total
          // including it rather than waiting another cycle for acc.
          if (p_v && p_last) begin
            state         <= HOLD;
            bus.out_valid <= 1'b1;
            bus.out_acc   <= acc_nxt;
            bus.out_cnt   <= cnt_nxt;
            bus.out_ovf   <= ovf | add_ovf;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mac_acc.sv
// -----------------------------------------------------------------------------
// tb_booth_mac_acc
// Three instances share one stimulus stream: 72-bit unsigned (default build),
// 64-bit unsigned (overflow case) and 72-bit signed. A reference model
// computes each instance's block total when a block closes and pushes it to
// a scoreboard queue; results are popped and compared on the out handshake.
// Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_booth_mac_acc;
  localparam int LENGTH    = 32;
  localparam int MAX_BEATS = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  booth_mac_acc_if #(.LENGTH(LENGTH), .ACC_WIDTH(72), .MAX_BEATS(MAX_BEATS)) bus_u ();
  booth_mac_acc_if #(.LENGTH(LENGTH), .ACC_WIDTH(64), .MAX_BEATS(MAX_BEATS)) bus_w ();
  booth_mac_acc_if #(.LENGTH(LENGTH), .ACC_WIDTH(72), .MAX_BEATS(MAX_BEATS)) bus_s ();

  booth_mac_acc #(.LENGTH(LENGTH), .ACC_WIDTH(72), .MAX_BEATS(MAX_BEATS), .UNSIGNED_MODE(1'b1))
    dut_u (.clk(clk), .rst(rst), .bus(bus_u));
  booth_mac_acc #(.LENGTH(LENGTH), .ACC_WIDTH(64), .MAX_BEATS(MAX_BEATS), .UNSIGNED_MODE(1'b1))
    dut_w (.clk(clk), .rst(rst), .bus(bus_w));
  booth_mac_acc #(.LENGTH(LENGTH), .ACC_WIDTH(72), .MAX_BEATS(MAX_BEATS), .UNSIGNED_MODE(1'b0))
    dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  typedef struct packed {
    logic [2:0][79:0] acc;
    logic [2:0]       ovf;
    logic [7:0]       cnt;
  } exp_t;

  exp_t sb_q[$];

  int   n_checks = 0;
  int   n_err    = 0;
  int   cfg_w [3] = '{72, 64, 72};
  bit   cfg_s [3] = '{1'b0, 1'b0, 1'b1};
  logic [79:0] m_acc [3];
  logic        m_ovf [3];
  int          m_cnt;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int c = 0; c < 3; c++) begin
      m_acc[c] = '0;
      m_ovf[c] = 1'b0;
    end
    m_cnt = 0;
  endfunction

  function automatic void model_add(input int c, input logic [63:0] prod);
    logic [79:0] mask, ext, sum;
    logic        sa, sb, o;
    int          w;
    w    = cfg_w[c];
    mask = (80'd1 << w) - 80'd1;
    if (cfg_s[c] && prod[63]) ext = {16'hFFFF, prod} & mask;
    else                      ext = {16'h0000, prod};
    sum = m_acc[c] + ext;
    sa  = m_acc[c][w-1];
    sb  = ext[w-1];
    if (cfg_s[c]) o = (sa == sb) && (sum[w-1] != sa);
    else          o = sum[w];
    sum = sum & mask;
`ifdef BOOTH_ACC_SAT_EN
    if (o) begin
      if (!cfg_s[c]) sum = mask;
      else if (sa)   sum = 80'd1 << (w - 1);
      else           sum = mask >> 1;
    end
`endif
    m_acc[c] = sum;
    m_ovf[c] = m_ovf[c] | o;
  endfunction

  function automatic void model_accept(input logic [63:0] prod, input logic last);
    exp_t e;
    m_cnt++;
    for (int c = 0; c < 3; c++) model_add(c, prod);
    if (last || m_cnt == MAX_BEATS) begin
      for (int c = 0; c < 3; c++) begin
        e.acc[c] = m_acc[c];
        e.ovf[c] = m_ovf[c];
      end
      e.cnt = 8'(m_cnt);
      sb_q.push_back(e);
      model_clear();
    end
  endfunction

  task automatic drive(input logic v, input logic [63:0] prod, input logic last);
    bus_u.in_valid = v; bus_w.in_valid = v; bus_s.in_valid = v;
    bus_u.in_prod  = prod; bus_w.in_prod = prod; bus_s.in_prod = prod;
    bus_u.in_last  = last; bus_w.in_last = last; bus_s.in_last = last;
  endtask

  task automatic set_ordy(input logic r);
    bus_u.out_ready = r; bus_w.out_ready = r; bus_s.out_ready = r;
  endtask

  // Inputs for the coming rising edge are already set: record an accept into
  // the model, score a result handshake, then advance to the next falling edge.
  task automatic clk_step();
    exp_t e;
    if (bus_u.in_valid && bus_u.in_ready) model_accept(bus_u.in_prod, bus_u.in_last);
    if (bus_u.out_valid && bus_u.out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra_result", 80'd1, 80'd0);
      end else begin
        e = sb_q.pop_front();
        check("u_acc", 80'(bus_u.out_acc), e.acc[0]);
        check("u_cnt", 80'(bus_u.out_cnt), 80'(e.cnt));
        check("u_ovf", 80'(bus_u.out_ovf), 80'(e.ovf[0]));
        check("w_valid", 80'(bus_w.out_valid), 80'd1);
        check("w_acc", 80'(bus_w.out_acc), e.acc[1]);
        check("w_ovf", 80'(bus_w.out_ovf), 80'(e.ovf[1]));
        check("s_valid", 80'(bus_s.out_valid), 80'd1);
        check("s_acc", 80'(bus_s.out_acc), e.acc[2]);
        check("s_ovf", 80'(bus_s.out_ovf), 80'(e.ovf[2]));
      end
    end
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [63:0] prod, input logic last);
    int t = 0;
    drive(1'b1, prod, last);
    while (!bus_u.in_ready && t < 50) begin
      clk_step();
      t++;
    end
    if (!bus_u.in_ready) check("send_timeout", 80'd0, 80'd1);
    else                 clk_step();
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0);
    repeat (n) clk_step();
  endtask

  task automatic drain();
    int t = 0;
    drive(1'b0, '0, 1'b0);
    while (sb_q.size() != 0 && t < 60) begin
      clk_step();
      t++;
    end
    check("drain_pending", 80'(sb_q.size()), 80'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    set_ordy(1'b0);
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 80'(bus_u.out_valid), 80'd0);
    check("rst_out_acc",   80'(bus_u.out_acc),   80'd0);
    check("rst_out_cnt",   80'(bus_u.out_cnt),   80'd0);
    check("rst_out_ovf",   80'(bus_u.out_ovf),   80'd0);
    check("rst_in_ready",  80'(bus_u.in_ready),  80'd1);
    rst = 1'b0;
    set_ordy(1'b1);
    @(negedge clk);

    // 3+5+7, result two cycles after the last accept, one-cycle pulse
    send_beat(64'd3, 1'b0);
    send_beat(64'd5, 1'b0);
    send_beat(64'd7, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("t1_drain_rdy", 80'(bus_u.in_ready),  80'd0);
    check("t1_lat_n1",    80'(bus_u.out_valid), 80'd0);
    clk_step();
    check("t1_lat_n2",    80'(bus_u.out_valid), 80'd1);
    check("t1_acc",       80'(bus_u.out_acc),   80'd15);
    clk_step();
    check("t1_pulse",     80'(bus_u.out_valid), 80'd0);

    // Bubbles inside a block add nothing
    send_beat(64'd5, 1'b0);
    idle(3);
    send_beat(64'd6, 1'b1);
    drain();

    // Backpressure: next block's beat waits with in_valid high
    set_ordy(1'b0);
    send_beat(64'd10, 1'b0);
    send_beat(64'd20, 1'b1);
    drive(1'b1, 64'd40, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("t2_rdy_low", 80'(bus_u.in_ready), 80'd0);
      if (i > 0) begin
        check("t2_hold_valid", 80'(bus_u.out_valid), 80'd1);
        check("t2_hold_acc",   80'(bus_u.out_acc),   80'd30);
      end
      clk_step();
    end
    set_ordy(1'b1);
    clk_step();
    check("t2_next_rdy", 80'(bus_u.in_ready), 80'd1);
    clk_step();
    drain();

    // Beat limit: 16 ones force-close; the remaining 4 form the next block,
    // closed by in_last on the 20th beat.
    for (int i = 0; i < 20; i++) send_beat(64'd1, (i == 19));
    drain();

    // in_last on the MAX_BEATS-th beat closes exactly once
    for (int i = 0; i < MAX_BEATS; i++) send_beat(64'd2, (i == MAX_BEATS - 1));
    drain();
    idle(6);
    check("t3_single_close", 80'(bus_u.out_valid), 80'd0);

    // Overflow of the 64-bit accumulator
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_beat(64'd2, 1'b1);
    drain();
`ifdef BOOTH_ACC_SAT_EN
    check("t4_w_acc", 80'(bus_w.out_acc), 80'hFFFF_FFFF_FFFF_FFFF);
`else
    check("t4_w_acc", 80'(bus_w.out_acc), 80'h1);
`endif
    check("t4_w_ovf", 80'(bus_w.out_ovf), 80'd1);

    // Signed: -6 + 2 = -4 across 72 bits
    send_beat(64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    send_beat(64'd2, 1'b1);
    drain();
    check("t5_s_acc", 80'(bus_s.out_acc), 80'h00_FF_FFFF_FFFF_FFFF_FFFC);
    check("t5_s_ovf", 80'(bus_s.out_ovf), 80'd0);

    // Reset mid-block discards the partial 7+9
    send_beat(64'd7, 1'b0);
    send_beat(64'd9, 1'b0);
    drive(1'b0, '0, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_rdy",   80'(bus_u.in_ready),  80'd1);
    check("t6_rst_valid", 80'(bus_u.out_valid), 80'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_beat(64'd4, 1'b1);
    drain();
    check("t6_acc", 80'(bus_u.out_acc), 80'd4);
    check("t6_cnt", 80'(bus_u.out_cnt), 80'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
